uds_fetch: RTL



---
 rtl/uds_fetch.sv | 109 ++++++++++
 1 files changed

// File: rtl/uds_fetch.sv
// rtl/uds_fetch.sv - one-shot sequencer draining the read-once UDS words onto a key stream
module uds_fetch #(
  parameter int NUM_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        app_mode,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        uds_cs,
  output logic [2:0]  uds_address,
  input  logic [31:0] uds_read_data,
  input  logic        uds_ready,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [2:0]  key_index,
  output logic [31:0] key_data
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_PUSH, S_DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  idx, idx_next;
  logic [31:0] data_buf, buf_next;
  logic        used, used_next;
  logic        error_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      data_buf <= '0;
      used     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      data_buf <= buf_next;
      used     <= used_next;
      error    <= error_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    buf_next   = data_buf;
    used_next  = used;
    error_next = error;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (app_mode || used) begin
            error_next = 1'b1;
          end else begin
            idx_next   = '0;
            state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (app_mode) begin
          state_next = S_IDLE;
          buf_next   = '0;
          used_next  = 1'b1;
          error_next = 1'b1;
        end else if (uds_ready) begin
          buf_next   = uds_read_data;
          state_next = S_PUSH;
        end
      end
      S_PUSH: begin
        if (app_mode) begin
          state_next = S_IDLE;
          buf_next   = '0;
          used_next  = 1'b1;
          error_next = 1'b1;
        end else if (key_ready) begin
          buf_next = '0;
          if (idx == LAST_IDX) begin
            used_next  = 1'b1;
            state_next = S_DONE;
          end else begin
            idx_next   = idx + 3'd1;
            state_next = S_REQ;
          end
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs see only registered state and the abort term, never the ready inputs.
  always_comb begin
    uds_cs      = (state == S_REQ) && !app_mode;
    key_valid   = (state == S_PUSH) && !app_mode;
    busy        = ((state == S_REQ) || (state == S_PUSH)) && !app_mode;
    done        = (state == S_DONE);
    uds_address = uds_cs ? idx : 3'd0;
    key_index   = key_valid ? idx : 3'd0;
    key_data    = key_valid ? data_buf : 32'd0;
  end

endmodule
